// File: rtl/cpu_mult_iter_cell.sv
// ---------------------------------------------------------------------------
// cpu_mult_iter_cell
//
// Iterative multiplier cell for the CPU A-stage. One SLICE_W x SLICE_W
// multiplier is reused across cycles. Each cycle it forms one slice-pair
// partial product and adds it, shifted into place, to an accumulator.
//
// Build option:
//   CPU_MULT_HIGH_EN  - when defined, the high-half ops (MULXSS/MULXSU/MULXUU)
//                       are supported. This adds a 2*DATA_W accumulator and a
//                       signed correction step. When undefined, every
//                       operation is treated as MUL (low half).
//
// Ports:
//   clk               - clock, rising edge
//   reset_n           - asynchronous active-low reset
//   A_mul_src1/src2   - operands, captured on an accepted start
//   A_mul_op          - 00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   A_mul_start       - request, accepted when not busy and not flushing
//   A_mul_flush       - abort the operation in flight
//   A_mul_busy        - operation in progress (MUL/DRAIN/FIX)
//   A_mul_done        - one-cycle pulse, result valid
//   A_mul_cell_result - registered result, held until the next done
// ---------------------------------------------------------------------------
module cpu_mult_iter_cell #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] A_mul_src1,
  input  logic [DATA_W-1:0] A_mul_src2,
  input  logic [1:0]        A_mul_op,
  input  logic              A_mul_start,
  input  logic              A_mul_flush,
  output logic              A_mul_busy,
  output logic              A_mul_done,
  output logic [DATA_W-1:0] A_mul_cell_result
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int POS_W = IDX_W + 1;
`ifdef CPU_MULT_HIGH_EN
  localparam int ACC_W = 2 * DATA_W;
`else
  localparam int ACC_W = DATA_W;
`endif
  // Headroom so that a shifted product never loses bits before truncation.
  localparam int EXT_W = ACC_W + 2 * SLICE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_r, state_nx_s;
  logic                   busy_r, busy_nx_s;
  logic                   done_r, done_nx_s;
  logic [DATA_W-1:0]      src1_r, src2_r;
  logic [ACC_W-1:0]       acc_r;
  logic [ACC_W-1:0]       acc_sum_s;
  logic [EXT_W-1:0]       addend_s;
  logic [2*SLICE_W-1:0]   prod_r;
  logic [POS_W-1:0]       prod_pos_r;
  logic                   prod_vld_r;
  logic [IDX_W-1:0]       i_r, j_r, j_max_s;
  logic                   last_pair_s;
  logic                   accept_s;
  logic                   high_s;
  logic [DATA_W-1:0]      result_r, result_nx_s;

`ifdef CPU_MULT_HIGH_EN
  logic                   high_r;
  logic                   s1_signed_r, s2_signed_r;
  logic [DATA_W-1:0]      corr1_s, corr2_s;
  assign high_s = high_r;
`else
  logic                   unused_op_s;
  assign unused_op_s = ^A_mul_op;
  assign high_s      = 1'b0;
`endif

  assign accept_s = A_mul_start && !A_mul_flush && !busy_r;

  // Low mode skips pairs with i+j >= N, so the inner index stops early.
  assign j_max_s     = high_s ? LAST_IDX : (LAST_IDX - i_r);
  assign last_pair_s = (i_r == LAST_IDX) && (j_r == j_max_s);

  // Registered product shifted to its slice position, then accumulated.
  assign addend_s  = EXT_W'(prod_r) << (prod_pos_r * SLICE_W);
  assign acc_sum_s = acc_r + addend_s[ACC_W-1:0];

  // State register together with the registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Next-state logic; flush aborts any busy state and beats a simultaneous start.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  state_nx_s = accept_s ? ST_MUL : ST_IDLE;
      ST_MUL: begin
        if (A_mul_flush) begin
          state_nx_s = ST_IDLE;
        end else if (last_pair_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_MUL;
        end
      end
      ST_DRAIN: state_nx_s = A_mul_flush ? ST_IDLE : ST_FIX;
      ST_FIX:   state_nx_s = A_mul_flush ? ST_IDLE : ST_DONE;
      ST_DONE:  state_nx_s = accept_s ? ST_MUL : ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode of the next state, registered in the state block above.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      ST_MUL, ST_DRAIN, ST_FIX: busy_nx_s = 1'b1;
      ST_DONE:                  done_nx_s = 1'b1;
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Final result: low half, or high half with two's-complement correction.
  always_comb begin
`ifdef CPU_MULT_HIGH_EN
    corr1_s = (s1_signed_r && src1_r[DATA_W-1]) ? src2_r : {DATA_W{1'b0}};
    corr2_s = (s2_signed_r && src2_r[DATA_W-1]) ? src1_r : {DATA_W{1'b0}};
    if (high_r) begin
      result_nx_s = acc_r[2*DATA_W-1:DATA_W] - corr1_s - corr2_s;
    end else begin
      result_nx_s = acc_r[DATA_W-1:0];
    end
`else
    result_nx_s = acc_r[DATA_W-1:0];
`endif
  end

  // Operand capture, slice multiplier, accumulator and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src1_r      <= {DATA_W{1'b0}};
      src2_r      <= {DATA_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      prod_r      <= {(2*SLICE_W){1'b0}};
      prod_pos_r  <= {POS_W{1'b0}};
      prod_vld_r  <= 1'b0;
      i_r         <= {IDX_W{1'b0}};
      j_r         <= {IDX_W{1'b0}};
      result_r    <= {DATA_W{1'b0}};
`ifdef CPU_MULT_HIGH_EN
      high_r      <= 1'b0;
      s1_signed_r <= 1'b0;
      s2_signed_r <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        src1_r      <= A_mul_src1;
        src2_r      <= A_mul_src2;
        acc_r       <= {ACC_W{1'b0}};
        prod_vld_r  <= 1'b0;
        i_r         <= {IDX_W{1'b0}};
        j_r         <= {IDX_W{1'b0}};
`ifdef CPU_MULT_HIGH_EN
        high_r      <= (A_mul_op != 2'b00);
        s1_signed_r <= (A_mul_op == 2'b01) || (A_mul_op == 2'b10);
        s2_signed_r <= (A_mul_op == 2'b01);
`endif
      end else if ((state_r == ST_MUL) && !A_mul_flush) begin
        // Product of pair (i,j) is registered; the previous one is added now.
        prod_r     <= src1_r[i_r*SLICE_W +: SLICE_W] * src2_r[j_r*SLICE_W +: SLICE_W];
        prod_pos_r <= {1'b0, i_r} + {1'b0, j_r};
        prod_vld_r <= 1'b1;
        if (prod_vld_r) begin
          acc_r <= acc_sum_s;
        end
        if (j_r == j_max_s) begin
          j_r <= {IDX_W{1'b0}};
          if (!last_pair_s) begin
            i_r <= i_r + IDX_W'(1);
          end
        end else begin
          j_r <= j_r + IDX_W'(1);
        end
      end else if ((state_r == ST_DRAIN) && !A_mul_flush) begin
        if (prod_vld_r) begin
          acc_r <= acc_sum_s;
        end
        prod_vld_r <= 1'b0;
      end

      if ((state_r == ST_FIX) && !A_mul_flush) begin
        result_r <= result_nx_s;
      end
    end
  end

  assign A_mul_busy        = busy_r;
  assign A_mul_done        = done_r;
  assign A_mul_cell_result = result_r;

endmodule

// File: tb/tb_cpu_mult_iter_cell.sv
// ---------------------------------------------------------------------------
// tb_cpu_mult_iter_cell
//
// Self-checking bench for cpu_mult_iter_cell. It drives a 32/16 instance with
// directed vectors and handshake corner cases, and a 64/16 instance with
// random operands and ops. Expected results come from a wide-integer
// reference multiply. Expected latencies come from the slice-pair count P.
// Honours CPU_MULT_HIGH_EN: when it is undefined, every op is expected to
// behave as MUL.
// ---------------------------------------------------------------------------
module tb_cpu_mult_iter_cell;

`ifdef CPU_MULT_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;

  logic [31:0] a_src1, a_src2, a_res;
  logic [1:0]  a_op;
  logic        a_start, a_flush, a_busy, a_done;

  logic [63:0] b_src1, b_src2, b_res;
  logic [1:0]  b_op;
  logic        b_start, b_flush, b_busy, b_done;

  int          errors;
  int          checks;
  logic [63:0] last_a, last_b;

  cpu_mult_iter_cell #(.DATA_W(32), .SLICE_W(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .A_mul_src1        (a_src1),
    .A_mul_src2        (a_src2),
    .A_mul_op          (a_op),
    .A_mul_start       (a_start),
    .A_mul_flush       (a_flush),
    .A_mul_busy        (a_busy),
    .A_mul_done        (a_done),
    .A_mul_cell_result (a_res)
  );

  cpu_mult_iter_cell #(.DATA_W(64), .SLICE_W(16)) dut_w (
    .clk               (clk),
    .reset_n           (reset_n),
    .A_mul_src1        (b_src1),
    .A_mul_src2        (b_src2),
    .A_mul_op          (b_op),
    .A_mul_start       (b_start),
    .A_mul_flush       (b_flush),
    .A_mul_busy        (b_busy),
    .A_mul_done        (b_done),
    .A_mul_cell_result (b_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision product of the operands interpreted per op.
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [1:0] op, input int w);
    logic [127:0] mask, xe, ye, p;
    mask = (128'd1 << w) - 128'd1;
    xe   = {64'd0, x} & mask;
    ye   = {64'd0, y} & mask;
    if (((op == 2'b01) || (op == 2'b10)) && x[w-1]) xe = xe | ~mask;
    if ((op == 2'b01) && y[w-1]) ye = ye | ~mask;
    p = xe * ye;
    if (op == 2'b00) return 64'(p & mask);
    return 64'((p >> w) & mask);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current time (just after an edge); intr: 0 none,
  // 1 extra start while busy before edge intr_edge, 2 flush before intr_edge.
  task automatic run_op(input bit wide, input logic [63:0] x, input logic [63:0] y,
                        input logic [1:0] op, input int intr, input int intr_edge,
                        input string tag);
    int          w, n, p, k;
    logic [1:0]  eop;
    logic [63:0] exp, prev;
    bit          seen;
    w    = wide ? 64 : 32;
    n    = w / 16;
    eop  = HIGH_EN ? op : 2'b00;
    p    = (eop == 2'b00) ? (n * (n + 1)) / 2 : n * n;
    exp  = model(x, y, eop, w);
    prev = wide ? last_b : last_a;
    if (wide) begin
      b_src1 = x; b_src2 = y; b_op = op; b_start = 1'b1;
    end else begin
      a_src1 = x[31:0]; a_src2 = y[31:0]; a_op = op; a_start = 1'b1;
    end
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    check({tag, "_busy"}, {63'd0, wide ? b_busy : a_busy}, 64'd1);
    seen = 1'b0;
    for (k = 1; k <= p + 10; k++) begin
      if ((intr == 1) && (k == intr_edge)) begin
        if (wide) begin
          b_src1 = ~x; b_src2 = ~y; b_op = ~op; b_start = 1'b1;
        end else begin
          a_src1 = ~x[31:0]; a_src2 = ~y[31:0]; a_op = ~op; a_start = 1'b1;
        end
      end
      if ((intr == 2) && (k == intr_edge)) begin
        if (wide) b_flush = 1'b1; else a_flush = 1'b1;
      end
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
      if ((intr == 2) && (k == intr_edge))
        check({tag, "_flush_busy"}, {63'd0, wide ? b_busy : a_busy}, 64'd0);
      if (wide ? b_done : a_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (intr == 2) begin
      check({tag, "_flush_nodone"}, {63'd0, seen}, 64'd0);
      check({tag, "_flush_res"}, wide ? b_res : {32'd0, a_res}, prev);
    end else begin
      check({tag, "_latency"}, 64'(k), 64'(p + 2));
      check({tag, "_res"}, wide ? b_res : {32'd0, a_res}, exp);
      check({tag, "_done_busy"}, {63'd0, wide ? b_busy : a_busy}, 64'd0);
      if (wide) last_b = exp; else last_a = exp;
    end
  endtask

  initial begin
    int          cnt;
    logic [63:0] rx, ry;
    logic [1:0]  rop;
    errors  = 0;
    checks  = 0;
    last_a  = 64'd0;
    last_b  = 64'd0;
    reset_n = 1'b0;
    a_src1 = 32'd0; a_src2 = 32'd0; a_op = 2'b00; a_start = 1'b0; a_flush = 1'b0;
    b_src1 = 64'd0; b_src2 = 64'd0; b_op = 2'b00; b_start = 1'b0; b_flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, a_busy}, 64'd0);
    check("rst_done", {63'd0, a_done}, 64'd0);
    check("rst_res", {32'd0, a_res}, 64'd0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_op(1'b0, 64'h0001_0003, 64'h0002_0005, 2'b00, 0, 0, "mul");
    check("mul_const", {32'd0, a_res}, 64'h0000_0000_000B_000F);
    @(posedge clk); #1;
    run_op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 2'b11, 0, 0, "mulxuu_ff");
    @(posedge clk); #1;
    run_op(1'b0, 64'hFFFF_FFFF, 64'h0000_0002, 2'b01, 0, 0, "mulxss");
    @(posedge clk); #1;
    run_op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 2'b10, 0, 0, "mulxsu");
    @(posedge clk); #1;
    run_op(1'b0, 64'hFFFF_FFFF, 64'h0000_0002, 2'b11, 0, 0, "mulxuu_2");
    @(posedge clk); #1;

    // Async reset in the middle of an operation
    a_src1 = 32'h1234_5678; a_src2 = 32'h9ABC_DEF0; a_op = 2'b00; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, a_busy}, 64'd0);
    check("midrst_done", {63'd0, a_done}, 64'd0);
    check("midrst_res", {32'd0, a_res}, 64'd0);
    last_a = 64'd0;
    last_b = 64'd0;
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 64'h0000_0007, 64'h0000_0009, 2'b00, 0, 0, "after_rst");
    @(posedge clk); #1;

    // Flush after edge 2, then a clean operation
    run_op(1'b0, 64'hDEAD_BEEF, 64'h0BAD_F00D, 2'b00, 2, 3, "flush");
    run_op(1'b0, 64'hDEAD_BEEF, 64'h0BAD_F00D, 2'b00, 0, 0, "post_flush");
    @(posedge clk); #1;

    // Start while busy is ignored
    run_op(1'b0, 64'h8000_0001, 64'h7FFF_FFFF, 2'b01, 1, 2, "start_busy");

    // Start during DONE is accepted back-to-back
    run_op(1'b0, 64'hCAFE_0001, 64'h0000_FFFF, 2'b00, 0, 0, "b2b_1");
    run_op(1'b0, 64'h8765_4321, 64'hF00F_0FF0, 2'b10, 0, 0, "b2b_2");
    @(posedge clk); #1;

    // Start and flush together in IDLE: nothing happens
    a_src1 = 32'h0000_0003; a_src2 = 32'h0000_0003; a_op = 2'b00;
    a_start = 1'b1; a_flush = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_flush = 1'b0;
    check("sf_busy", {63'd0, a_busy}, 64'd0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (a_done) cnt++;
    end
    check("sf_nodone", 64'(cnt), 64'd0);
    check("sf_res", {32'd0, a_res}, last_a);

    // Random ops on both widths
    for (int r = 0; r < 8; r++) begin
      rx  = {32'd0, $urandom};
      ry  = {32'd0, $urandom};
      rop = 2'($urandom_range(0, 3));
      run_op(1'b0, rx, ry, rop, 0, 0, "rand32");
      @(posedge clk); #1;
    end
    for (int r = 0; r < 20; r++) begin
      rx  = {$urandom, $urandom};
      ry  = {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      if (r == 0) begin rx = 64'hFFFF_FFFF_FFFF_FFFF; ry = 64'hFFFF_FFFF_FFFF_FFFF; end
      if (r == 1) begin rx = 64'h8000_0000_0000_0000; ry = 64'h8000_0000_0000_0000; rop = 2'b01; end
      run_op(1'b1, rx, ry, rop, 0, 0, "rand64");
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
